// File: rtl/datapath_if.sv
// Control, memory-data and observation signals shared by the datapath and
// whatever sequences it (control unit or bench).
interface datapath_if;
  // Bus-drive selects
  logic [15:0] R_wrt;
  logic        HI_out;
  logic        LO_out;
  logic        Zhi_out;
  logic        Zlo_out;
  logic        PC_out;
  logic        MDR_out;
  logic        MAR_out;
  logic        In_out;
  logic        C_out;

  // Load enables
  logic [15:0] R_rd;
  logic        MAR_rd;
  logic        Zlo_rd;
  logic        PC_rd;
  logic        MDR_rd;
  logic        IR_rd;
  logic        Y_rd;
  logic        IncPC;

  logic        Read;
  logic [4:0]  op_sel;
  logic [31:0] Mdatain;

  // Observation
  logic [31:0] r3_view;
  logic [31:0] r4_view;
  logic [31:0] r7_view;
  logic [31:0] Y_view;
  logic [31:0] Zlo_view;
  logic [31:0] MDR_view;
  logic [31:0] PC_view;
  logic [31:0] IR_view;   // instruction word for the control unit's decoder
  logic [31:0] BusMuxOut;
  logic [31:0] Data_view;

  modport master (
    output R_wrt, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out,
           In_out, C_out, R_rd, MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd,
           IncPC, Read, op_sel, Mdatain,
    input  r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view,
           IR_view, BusMuxOut, Data_view
  );

  modport slave (
    input  R_wrt, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out,
           In_out, C_out, R_rd, MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd,
           IncPC, Read, op_sel, Mdatain,
    output r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view,
           IR_view, BusMuxOut, Data_view
  );
endinterface

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, PC, IR, MAR, MDR, Y, Zlo and
// ALU around one combinational bus, sequenced externally through datapath_if.
module datapath (
  input logic       clk,
  input logic       clr,
  datapath_if.slave dp
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [31:0] r_reg [16];
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] mar_reg;
  logic [31:0] mdr_reg;
  logic [31:0] y_reg;
  logic [31:0] zlo_reg;

  logic [31:0] bus;
  logic [31:0] mdr_next;
  logic [31:0] pc_next;
  logic [31:0] alu_result;
  logic [4:0]  shamt;
  logic [5:0]  shamt_inv;

  // Sources are applied from lowest to highest priority so the last match wins.
  always_comb begin
    bus = '0;
    if (dp.C_out || dp.In_out) bus = '0;
    if (dp.MAR_out)            bus = mar_reg;
    if (dp.MDR_out)            bus = mdr_reg;
    if (dp.PC_out)             bus = pc_reg;
    if (dp.Zlo_out)            bus = zlo_reg;
    if (dp.Zhi_out || dp.LO_out || dp.HI_out) bus = '0;
    for (int i = 15; i >= 0; i--) begin
      if (dp.R_wrt[i]) bus = r_reg[i];
    end
  end

  assign mdr_next  = dp.Read ? dp.Mdatain : bus;
  assign shamt     = bus[4:0];
  assign shamt_inv = 6'd32 - {1'b0, shamt};

  // A shift by 32 yields 0, so a rotate by 0 falls out of the same expression.
  always_comb begin
    alu_result = '0;
    case (dp.op_sel)
      OP_ADD:  alu_result = y_reg + bus;
      OP_SUB:  alu_result = y_reg - bus;
      OP_AND:  alu_result = y_reg & bus;
      OP_OR:   alu_result = y_reg | bus;
      OP_SHR:  alu_result = y_reg >> shamt;
      OP_SHRA: alu_result = $signed(y_reg) >>> shamt;
      OP_SHL:  alu_result = y_reg << shamt;
      OP_ROR:  alu_result = (y_reg >> shamt) | (y_reg << shamt_inv);
      OP_ROL:  alu_result = (y_reg << shamt) | (y_reg >> shamt_inv);
      OP_NEG:  alu_result = '0 - bus;
      OP_NOT:  alu_result = ~bus;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (dp.PC_rd)      pc_next = bus;
    else if (dp.IncPC) pc_next = pc_reg + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) r_reg[i] <= '0;
      pc_reg  <= '0;
      ir_reg  <= '0;
      mar_reg <= '0;
      mdr_reg <= '0;
      y_reg   <= '0;
      zlo_reg <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (dp.R_rd[i]) r_reg[i] <= bus;
      end
      if (dp.Y_rd)   y_reg   <= bus;
      if (dp.IR_rd)  ir_reg  <= bus;
      if (dp.MAR_rd) mar_reg <= bus;
      if (dp.MDR_rd) mdr_reg <= mdr_next;
      if (dp.Zlo_rd) zlo_reg <= alu_result;
      pc_reg <= pc_next;
    end
  end

  assign dp.r3_view   = r_reg[3];
  assign dp.r4_view   = r_reg[4];
  assign dp.r7_view   = r_reg[7];
  assign dp.Y_view    = y_reg;
  assign dp.Zlo_view  = zlo_reg;
  assign dp.MDR_view  = mdr_reg;
  assign dp.PC_view   = pc_reg;
  assign dp.IR_view   = ir_reg;
  assign dp.BusMuxOut = bus;
  assign dp.Data_view = mdr_next;

endmodule

// File: tb/tb_datapath.sv
// Directed plus randomized bench for datapath, checked against a behavioural
// register-transfer model of the bus, ALU and load rules.
module tb_datapath;

  logic clk = 1'b0;
  logic clr;

  datapath_if dpif ();

  datapath dut (
    .clk (clk),
    .clr (clr),
    .dp  (dpif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit bus_known = 1'b0;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zlo;
  logic [4:0]  valid_ops [11];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dpif.R_wrt = '0;   dpif.R_rd = '0;
    dpif.HI_out = 0;   dpif.LO_out = 0;  dpif.Zhi_out = 0; dpif.Zlo_out = 0;
    dpif.PC_out = 0;   dpif.MDR_out = 0; dpif.MAR_out = 0; dpif.In_out = 0;
    dpif.C_out = 0;    dpif.MAR_rd = 0;  dpif.Zlo_rd = 0;  dpif.PC_rd = 0;
    dpif.MDR_rd = 0;   dpif.IR_rd = 0;   dpif.Y_rd = 0;    dpif.IncPC = 0;
    dpif.Read = 0;     dpif.op_sel = '0; dpif.Mdatain = '0;
  endtask

  // First asserted source in the documented priority list wins.
  function automatic logic [31:0] ref_bus();
    for (int i = 0; i < 16; i++)
      if (dpif.R_wrt[i]) return m_r[i];
    if (dpif.HI_out || dpif.LO_out || dpif.Zhi_out) return 32'h0;
    if (dpif.Zlo_out) return m_zlo;
    if (dpif.PC_out)  return m_pc;
    if (dpif.MDR_out) return m_mdr;
    if (dpif.MAR_out) return m_mar;
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int n;
    logic [31:0] t;
    n = int'(b[4:0]);
    t = a;
    case (op)
      5'd3:  return a + b;
      5'd4:  return a - b;
      5'd5:  return a & b;
      5'd6:  return a | b;
      5'd7:  return a >> n;
      5'd8:  begin for (int k = 0; k < n; k++) t = {t[31], t[31:1]}; return t; end
      5'd9:  return a << n;
      5'd10: begin for (int k = 0; k < n; k++) t = {t[0], t[31:1]}; return t; end
      5'd11: begin for (int k = 0; k < n; k++) t = {t[30:0], t[31]}; return t; end
      5'd17: return 32'h0 - b;
      5'd18: return ~b;
      default: return 32'h0;
    endcase
  endfunction

  // Inputs are already driven; check the bus, advance the model and the DUT one edge.
  task automatic step();
    logic [31:0] bus, data, alu;
    #1;
    bus  = ref_bus();
    data = dpif.Read ? dpif.Mdatain : bus;
    alu  = ref_alu(dpif.op_sel, m_y, bus);
    if (bus_known) begin
      chk("bus", dpif.BusMuxOut, bus);
      chk("data_view", dpif.Data_view, data);
    end
    if (!clr) begin
      for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_zlo = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (dpif.R_rd[i]) m_r[i] = bus;
      if (dpif.Y_rd)   m_y   = bus;
      if (dpif.IR_rd)  m_ir  = bus;
      if (dpif.MAR_rd) m_mar = bus;
      if (dpif.MDR_rd) m_mdr = data;
      if (dpif.Zlo_rd) m_zlo = alu;
      if (dpif.PC_rd)      m_pc = bus;
      else if (dpif.IncPC) m_pc = m_pc + 32'd1;
    end
    @(posedge clk);
    #1;
    bus_known = 1'b1;
    chk("r3_view",  dpif.r3_view,  m_r[3]);
    chk("r4_view",  dpif.r4_view,  m_r[4]);
    chk("r7_view",  dpif.r7_view,  m_r[7]);
    chk("Y_view",   dpif.Y_view,   m_y);
    chk("Zlo_view", dpif.Zlo_view, m_zlo);
    chk("MDR_view", dpif.MDR_view, m_mdr);
    chk("PC_view",  dpif.PC_view,  m_pc);
    chk("IR_view",  dpif.IR_view,  m_ir);
  endtask

  task automatic read_mem(input logic [31:0] val);
    idle(); dpif.Mdatain = val; dpif.Read = 1; dpif.MDR_rd = 1; step();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] val);
    read_mem(val);
    idle(); dpif.MDR_out = 1; dpif.R_rd[idx] = 1'b1; step();
  endtask

  task automatic alu_op(input int src, input logic [4:0] op);
    idle(); dpif.R_wrt[src] = 1'b1; dpif.op_sel = op; dpif.Zlo_rd = 1; step();
  endtask

  task automatic peek_bus(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, dpif.BusMuxOut, exp);
  endtask

  initial begin
    valid_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd17, 5'd18};
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_zlo = 0;

    // Reset
    idle(); clr = 1'b0; step();
    clr = 1'b1;
    chk("reset_pc", dpif.PC_view, 32'h0);
    chk("reset_mdr", dpif.MDR_view, 32'h0);

    // Register loads via MDR
    load_reg(3, 32'h99);
    load_reg(4, 32'h14);
    load_reg(7, 32'hF6);
    chk("load_r3", dpif.r3_view, 32'h99);
    chk("load_r4", dpif.r4_view, 32'h14);
    chk("load_r7", dpif.r7_view, 32'hF6);

    // OR instruction
    read_mem(32'h2A2B8000);
    idle(); dpif.MDR_out = 1; dpif.IR_rd = 1; step();
    chk("or_ir", dpif.IR_view, 32'h2A2B8000);
    idle(); dpif.R_wrt[3] = 1'b1; dpif.Y_rd = 1; step();
    chk("or_y", dpif.Y_view, 32'h99);
    alu_op(7, 5'b00110);
    chk("or_zlo", dpif.Zlo_view, 32'hFF);
    idle(); dpif.Zlo_out = 1; dpif.R_rd[4] = 1'b1; step();
    chk("or_r4", dpif.r4_view, 32'hFF);

    // ALU sweep, Y=0x99
    alu_op(7, 5'b00011); chk("alu_add", dpif.Zlo_view, 32'h18F);
    alu_op(7, 5'b00100); chk("alu_sub", dpif.Zlo_view, 32'hFFFFFFA3);
    alu_op(7, 5'b00101); chk("alu_and", dpif.Zlo_view, 32'h90);
    alu_op(7, 5'b10010); chk("alu_not", dpif.Zlo_view, 32'hFFFFFF09);
    load_reg(5, 32'h4);
    alu_op(5, 5'b01001); chk("alu_shl", dpif.Zlo_view, 32'h990);
    alu_op(5, 5'b01010); chk("alu_ror", dpif.Zlo_view, 32'h90000009);
    alu_op(5, 5'b01011); chk("alu_rol", dpif.Zlo_view, 32'h990);
    alu_op(7, 5'b10001); chk("alu_neg", dpif.Zlo_view, 32'hFFFFFF0A);
    alu_op(5, 5'b11111); chk("alu_bad_op", dpif.Zlo_view, 32'h0);

    // PC path
    read_mem(32'hF6);
    idle(); dpif.MDR_out = 1; dpif.PC_rd = 1; step();
    chk("pc_load", dpif.PC_view, 32'hF6);
    idle(); dpif.IncPC = 1; step();
    chk("pc_inc", dpif.PC_view, 32'hF7);
    idle(); dpif.MDR_out = 1; dpif.PC_rd = 1; dpif.IncPC = 1; step();
    chk("pc_load_prio", dpif.PC_view, 32'hF6);
    read_mem(32'hFFFFFFFF);
    idle(); dpif.MDR_out = 1; dpif.PC_rd = 1; step();
    idle(); dpif.IncPC = 1; step();
    chk("pc_wrap", dpif.PC_view, 32'h0);

    // Bus defaults and priority
    idle();                                        peek_bus("bus_none", 32'h0);
    dpif.R_wrt[3] = 1'b1; dpif.R_wrt[7] = 1'b1;    peek_bus("bus_r3_over_r7", 32'h99);
    idle(); dpif.HI_out = 1;                       peek_bus("bus_hi", 32'h0);
    dpif.MDR_out = 1;                              peek_bus("bus_hi_over_mdr", 32'h0);

    // Reset mid-operation
    idle(); dpif.R_wrt[7] = 1'b1; dpif.op_sel = 5'b00011;
    dpif.Zlo_rd = 1; dpif.R_rd[4] = 1'b1; dpif.IncPC = 1; clr = 1'b0; step();
    clr = 1'b1;
    chk("rst_r3", dpif.r3_view, 32'h0);
    chk("rst_r4", dpif.r4_view, 32'h0);
    chk("rst_r7", dpif.r7_view, 32'h0);
    chk("rst_y", dpif.Y_view, 32'h0);
    chk("rst_zlo", dpif.Zlo_view, 32'h0);
    chk("rst_mdr", dpif.MDR_view, 32'h0);
    chk("rst_pc", dpif.PC_view, 32'h0);
    chk("rst_ir", dpif.IR_view, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      clr = ($urandom_range(0, 39) != 0);
      dpif.R_rd    = 16'($urandom & $urandom & $urandom);
      dpif.R_wrt   = 16'($urandom & $urandom & $urandom & $urandom);
      dpif.HI_out  = ($urandom_range(0, 9) == 0);
      dpif.LO_out  = ($urandom_range(0, 9) == 0);
      dpif.Zhi_out = ($urandom_range(0, 9) == 0);
      dpif.Zlo_out = ($urandom_range(0, 4) == 0);
      dpif.PC_out  = ($urandom_range(0, 4) == 0);
      dpif.MDR_out = ($urandom_range(0, 3) == 0);
      dpif.MAR_out = ($urandom_range(0, 4) == 0);
      dpif.In_out  = ($urandom_range(0, 7) == 0);
      dpif.C_out   = ($urandom_range(0, 7) == 0);
      dpif.MAR_rd  = ($urandom_range(0, 3) == 0);
      dpif.Zlo_rd  = ($urandom_range(0, 1) == 0);
      dpif.PC_rd   = ($urandom_range(0, 4) == 0);
      dpif.MDR_rd  = ($urandom_range(0, 2) == 0);
      dpif.IR_rd   = ($urandom_range(0, 4) == 0);
      dpif.Y_rd    = ($urandom_range(0, 2) == 0);
      dpif.IncPC   = ($urandom_range(0, 2) == 0);
      dpif.Read    = ($urandom_range(0, 1) == 0);
      dpif.Mdatain = $urandom;
      if ($urandom_range(0, 3) != 0) dpif.op_sel = valid_ops[$urandom_range(0, 10)];
      else                           dpif.op_sel = 5'($urandom_range(0, 31));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Single-bus 32-bit CPU datapath: sixteen general registers, PC, IR, MAR, MDR, Y, Z and an ALU share one combinational bus (BusMuxOut). An external control unit or testbench sequences it with one-hot bus-source selects and per-register load enables. View ports expose internal state for bring-up and verification. The block sits between the control unit and the memory interface. Memory data enters only through Mdatain.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  reset, synchronous, active-low
- R_rd  in  16  load enables for R0..R15; bit i loads Ri from BusMuxOut
- R_wrt  in  16  bus-drive selects for R0..R15
- HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out  in  1 each  bus-drive selects
- MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd  in  1 each  register load enables
- IncPC  in  1  increment PC
- Read  in  1  MDR input select: 1 = Mdatain, 0 = BusMuxOut
- op_sel  in  5  ALU operation
- Mdatain  in  32  memory read data
- r3_view, r4_view, r7_view  out  32  contents of R3, R4, R7
- Y_view, Zlo_view, MDR_view, PC_view  out  32  register contents
- BusMuxOut  out  32  current bus value
- Data_view  out  32  MDR input mux value: Read ? Mdatain : BusMuxOut

## Operation
- Bus mux is combinational. Fixed priority when several selects are high: R0..R15 (lowest index first), HI, LO, Zhi, Zlo, PC, MDR, MAR, In, C. With no select asserted, the bus is 32'h0.
- HI, LO and Zhi have no load path and always read 0. The In_out and C_out sources also drive 0.
- Y, IR, MAR and R0..R15 load BusMuxOut when their enable is high. R0 is an ordinary register.
- MDR loads Data_view when MDR_rd is high.
- PC behaviour:
  - PC_rd=1: PC loads BusMuxOut.
  - Otherwise, IncPC=1: PC <= PC + 1, wrapping at 32'hFFFFFFFF to 0.
  - PC_rd has priority over IncPC.
- ALU:
  - Operand A is Y; operand B is BusMuxOut.
  - Zlo loads the ALU result when Zlo_rd is high.
  - For shift and rotate operations, the amount is B[4:0].
- op_sel encoding:
  - 00011 add: A+B, mod 2^32.
  - 00100 sub: A−B, mod 2^32.
  - 00101 and; 00110 or.
  - 00111 shr (logical); 01000 shra (arithmetic); 01001 shl.
  - 01010 ror; 01011 rol.
  - 10001 neg: −B.
  - 10010 not: ~B.
  - Any other code: result 0.
- View ports are continuous copies of the register contents.

## Timing
- Every register updates only on the rising edge of clk. Control inputs are sampled at that edge.
- Reset:
  - clr=0 at an edge clears all registers (R0..R15, PC, IR, MAR, MDR, Y, Zlo) to 0.
  - Reset overrides all load enables and IncPC, including mid-sequence.
  - While in reset, BusMuxOut still follows its sources; those sources are 0 after the first reset edge.
- Register-to-register transfer takes 1 cycle: assert source select + destination enable, and the value appears at the destination output after the edge.
- ALU path: Y loaded in cycle n; op_sel plus the B source plus Zlo_rd in cycle n+1; Zlo is valid after that edge.
- Memory read: Read=1 with MDR_rd=1 makes MDR = Mdatain after the edge.
- A register that is both bus source and destination in the same cycle reloads its own old value.

## Test plan
- Register loads via MDR:
  - Stimulus: clr low for one edge, then high. Mdatain=0x99, Read=1, MDR_rd=1 for one edge. Then MDR_out=1, R_rd[3]=1 for one edge. Repeat with 0x14→R4 and 0xF6→R7.
  - Response: r3_view=0x99, r4_view=0x14, r7_view=0xF6.
- OR instruction:
  - Stimulus: Mdatain=0x2A2B8000 read into MDR, then MDR_out+IR_rd. R_wrt[3]+Y_rd. Then R_wrt[7], op_sel=00110, Zlo_rd. Then Zlo_out+R_rd[4].
  - Response: Y_view=0x99, Zlo_view=0xFF, r4_view=0xFF.
- ALU sweep with Y=0x99, B=0xF6:
  - add → 0x18F
  - sub → 0xFFFFFFA3
  - and → 0x90
  - not → 0xFFFFFF09
  - With B=4: shl → 0x990, ror → 0x90000009.
- PC path:
  - MDR_out+PC_rd with MDR=0xF6 → PC_view=0xF6.
  - IncPC for one edge → 0xF7.
  - PC_rd and IncPC together → the loaded bus value.
  - PC=0xFFFFFFFF plus IncPC → 0.
- Bus defaults and priority:
  - No select asserted → BusMuxOut=0.
  - R_wrt[3] and R_wrt[7] together → R3 value.
  - HI_out alone → 0.
- Reset mid-operation:
  - Stimulus: clr=0 on the same edge as Zlo_rd=1 and R_rd[4]=1.
  - Response: all views read 0 afterward.
